// File: rtl/jtag_shift_master.sv
`default_nettype none
// ============================================================================
// Module   : jtag_shift_master
// Brief    : Command-driven JTAG initiator. Shifts 1-32 TMS/TDI bits per
//            command on a divided TCK and returns the captured TDO bits.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_shift_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        io_axiClk,
  input  logic        io_asyncResetn,
  input  logic        io_cmd_valid,
  output logic        io_cmd_ready,
  input  logic [4:0]  io_cmd_length,
  input  logic [31:0] io_cmd_tms,
  input  logic [31:0] io_cmd_tdi,
  output logic        io_rsp_valid,
  input  logic        io_rsp_ready,
  output logic [31:0] io_rsp_tdo,
  output logic        io_busy,
  output logic        io_jtag_tck,
  output logic        io_jtag_tms,
  output logic        io_jtag_tdi,
  input  logic        io_jtag_tdo
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_low  = 2'd1;
  localparam logic [1:0] c_st_high = 2'd2;
  localparam logic [1:0] c_st_resp = 2'd3;

  // The first LOW phase gets one extra cycle so TMS/TDI of bit 0 are set up
  // a full cycle before the LOW period proper starts.
  localparam logic [7:0] c_phase_first  = 8'(CLK_DIV);
  localparam logic [7:0] c_phase_reload = 8'(CLK_DIV - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_phase_cnt;
  logic [4:0]  r_idx;
  logic [4:0]  r_len;
  logic [31:0] r_tms_vec;
  logic [31:0] r_tdi_vec;
  logic [31:0] r_capture;
  logic        r_tdo_meta;
  logic        r_tdo_sync;

  logic        r_tck;
  logic        r_tms;
  logic        r_tdi;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_tdo;
  logic        r_busy;

  logic        w_accept;
  logic        w_phase_done;
  logic        w_last_bit;
  logic [4:0]  w_idx_inc;
  logic [31:0] w_capture_upd;

  logic        w_tck_nxt;
  logic        w_tms_nxt;
  logic        w_tdi_nxt;
  logic        w_cmd_ready_nxt;
  logic        w_rsp_valid_nxt;
  logic [31:0] w_rsp_tdo_nxt;
  logic        w_busy_nxt;

  assign w_accept     = io_cmd_valid && (r_state == c_st_idle);
  assign w_phase_done = (r_phase_cnt == 8'd0);
  assign w_last_bit   = (r_idx == r_len);
  assign w_idx_inc    = r_idx + 5'd1;

  always_comb begin
    w_capture_upd        = r_capture;
    w_capture_upd[r_idx] = r_tdo_sync;
  end

  // State register
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept)     w_state_nxt = c_st_low;
      c_st_low:  if (w_phase_done) w_state_nxt = c_st_high;
      c_st_high: begin
        if (w_phase_done) w_state_nxt = w_last_bit ? c_st_resp : c_st_low;
      end
      c_st_resp: if (io_rsp_ready) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_tck_nxt       = (w_state_nxt == c_st_high);
    w_cmd_ready_nxt = (w_state_nxt == c_st_idle);
    w_busy_nxt      = (w_state_nxt != c_st_idle);
    w_rsp_valid_nxt = (w_state_nxt == c_st_resp);
    w_tms_nxt       = r_tms;
    w_tdi_nxt       = r_tdi;
    w_rsp_tdo_nxt   = r_rsp_tdo;
    if (w_accept) begin
      w_tms_nxt = io_cmd_tms[0];
      w_tdi_nxt = io_cmd_tdi[0];
    end else if ((r_state == c_st_high) && w_phase_done) begin
      if (w_last_bit) begin
        w_rsp_tdo_nxt = w_capture_upd;
      end else begin
        w_tms_nxt = r_tms_vec[w_idx_inc];
        w_tdi_nxt = r_tdi_vec[w_idx_inc];
      end
    end
  end

  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      r_phase_cnt <= 8'd0;
      r_idx       <= 5'd0;
      r_len       <= 5'd0;
      r_tms_vec   <= 32'd0;
      r_tdi_vec   <= 32'd0;
      r_capture   <= 32'd0;
      r_tdo_meta  <= 1'b0;
      r_tdo_sync  <= 1'b0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_tdo   <= 32'd0;
      r_busy      <= 1'b0;
    end else begin
      r_tdo_meta  <= io_jtag_tdo;
      r_tdo_sync  <= r_tdo_meta;
      r_tck       <= w_tck_nxt;
      r_tms       <= w_tms_nxt;
      r_tdi       <= w_tdi_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_tdo   <= w_rsp_tdo_nxt;
      r_busy      <= w_busy_nxt;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_tms_vec   <= io_cmd_tms;
            r_tdi_vec   <= io_cmd_tdi;
            r_len       <= io_cmd_length;
            r_capture   <= 32'd0;
            r_idx       <= 5'd0;
            r_phase_cnt <= c_phase_first;
          end
        end
        c_st_low: begin
          r_phase_cnt <= w_phase_done ? c_phase_reload : (r_phase_cnt - 8'd1);
        end
        c_st_high: begin
          if (w_phase_done) begin
            // TDO is stable through HIGH, so the synchronized copy is current here
            r_capture   <= w_capture_upd;
            r_phase_cnt <= c_phase_reload;
            if (!w_last_bit) r_idx <= w_idx_inc;
          end else begin
            r_phase_cnt <= r_phase_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_cmd_ready = r_cmd_ready;
  assign io_rsp_valid = r_rsp_valid;
  assign io_rsp_tdo   = r_rsp_tdo;
  assign io_busy      = r_busy;
  assign io_jtag_tck  = r_tck;
  assign io_jtag_tms  = r_tms;
  assign io_jtag_tdi  = r_tdi;

endmodule
`default_nettype wire

// File: tb/tb_jtag_shift_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_shift_master
// Brief    : Bench for jtag_shift_master with a TAP model and a TDO pattern
//            source; two instances cover CLK_DIV 4 and the minimum of 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_shift_master;

  localparam int c_div0 = 4;
  localparam int c_div1 = 3;
  localparam logic [31:0] c_idcode = 32'h10001FFF;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PAUDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

  logic clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  logic [1:0] cmd_valid = 2'b00;
  logic [1:0] rsp_ready = 2'b00;
  logic [1:0] cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [1:0][4:0]  cmd_len = '0;
  logic [1:0][31:0] cmd_tms = '0;
  logic [1:0][31:0] cmd_tdi = '0;
  logic [1:0][31:0] rsp_tdo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    jtag_shift_master #(.CLK_DIV(g == 0 ? c_div0 : c_div1)) u_dut (
      .io_axiClk      (clk),
      .io_asyncResetn (rst_n[g]),
      .io_cmd_valid   (cmd_valid[g]),
      .io_cmd_ready   (cmd_ready[g]),
      .io_cmd_length  (cmd_len[g]),
      .io_cmd_tms     (cmd_tms[g]),
      .io_cmd_tdi     (cmd_tdi[g]),
      .io_rsp_valid   (rsp_valid[g]),
      .io_rsp_ready   (rsp_ready[g]),
      .io_rsp_tdo     (rsp_tdo[g]),
      .io_busy        (busy[g]),
      .io_jtag_tck    (tck[g]),
      .io_jtag_tms    (tms[g]),
      .io_jtag_tdi    (tdi[g]),
      .io_jtag_tdo    (tdo[g])
    );
  end

  // Behavioural TAP on instance 0: IEEE 1149.1 state graph, IDCODE data register
  int          tap_st  = TLR;
  logic [31:0] tap_dr  = '0;
  logic        tap_tdo = 1'b0;
  logic        use_tap = 1'b0;
  int falls0 = 0, falls1 = 0, rises0 = 0, rises1 = 0;
  int base0 = 0, base1 = 0;
  logic [31:0] pat0 = '0, pat1 = '0;
  int d0, d1;

  function automatic int tap_next(input int st, input logic m);
    case (st)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PAUDR;
      PAUDR:   return m ? EX2DR : PAUDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAUIR;
      PAUIR:   return m ? EX2IR : PAUIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck[0]) begin
    rises0 <= rises0 + 1;
    if (tap_st == CAPDR)     tap_dr <= c_idcode;
    else if (tap_st == SHDR) tap_dr <= {tdi[0], tap_dr[31:1]};
    tap_st <= tap_next(tap_st, tms[0]);
  end

  always @(negedge tck[0]) begin
    falls0  <= falls0 + 1;
    tap_tdo <= (tap_st == SHDR) ? tap_dr[0] : 1'b0;
  end

  always @(posedge tck[1]) rises1 <= rises1 + 1;
  always @(negedge tck[1]) falls1 <= falls1 + 1;

  // Pattern source: bit i of the pattern is on TDO after the i-th TCK fall of a command
  assign d0 = falls0 - base0;
  assign d1 = falls1 - base1;
  assign tdo[0] = use_tap ? tap_tdo : ((d0 >= 0 && d0 < 32) ? pat0[d0[4:0]] : 1'b0);
  assign tdo[1] = (d1 >= 0 && d1 < 32) ? pat1[d1[4:0]] : 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input int u);
    return (u == 0) ? c_div0 : c_div1;
  endfunction

  function automatic logic [31:0] len_mask(input logic [4:0] len);
    return (len == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (int'(len) + 1)) - 32'd1);
  endfunction

  // {tck, tms, tdi, rsp_valid, busy, cmd_ready}
  function automatic logic [5:0] pins(input int u);
    return {tck[u], tms[u], tdi[u], rsp_valid[u], busy[u], cmd_ready[u]};
  endfunction

  function automatic int rises_of(input int u);
    return (u == 0) ? rises0 : rises1;
  endfunction

  task automatic load_pattern(input int u, input logic [31:0] p);
    if (u == 0) begin
      pat0  = p;
      base0 = falls0;
    end else begin
      pat1  = p;
      base1 = falls1;
    end
  endtask

  // Issue one command and check every cycle against the bit-timing rules:
  // bit k is LOW on cycles [1+2kD, 1+(2k+1)D) and HIGH on [1+(2k+1)D, 1+(2k+2)D)
  // after the accept edge; the response appears with the final TCK fall.
  task automatic run_cmd(input int u, input logic [4:0] len, input logic [31:0] tv,
                         input logic [31:0] dv, input logic [31:0] exp_tdo,
                         input int hold, input string tag);
    int d, t, m, k, r0;
    logic [5:0] exp_pins;
    d = div_of(u);
    t = 1 + 2 * (int'(len) + 1) * d;
    @(negedge clk);
    check({tag, " ready"}, 64'(cmd_ready[u]), 64'd1);
    cmd_valid[u] = 1'b1;
    cmd_len[u]   = len;
    cmd_tms[u]   = tv;
    cmd_tdi[u]   = dv;
    rsp_ready[u] = (hold == 0);
    r0 = rises_of(u);
    @(posedge clk);
    #1;
    cmd_valid[u] = 1'b0;
    cmd_tms[u]   = $urandom();
    cmd_tdi[u]   = $urandom();
    cmd_len[u]   = 5'($urandom_range(0, 31));
    for (int n = 1; n <= t; n++) begin
      @(posedge clk);
      #1;
      m = n - 1;
      k = (n < t) ? m / (2 * d) : int'(len);
      exp_pins = {(n < t) && ((m / d) % 2 == 1), tv[k], dv[k], (n == t), 1'b1, 1'b0};
      check($sformatf("%s pins@%0d", tag, n), 64'(pins(u)), 64'(exp_pins));
    end
    check({tag, " tdo"}, 64'(rsp_tdo[u]), 64'(exp_tdo));
    check({tag, " pulses"}, 64'(rises_of(u) - r0), 64'(int'(len) + 1));
    for (int h = 0; h < hold; h++) begin
      if (h == hold / 2) cmd_valid[u] = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid[u] = 1'b0;
      check($sformatf("%s hold pins@%0d", tag, h), 64'(pins(u)),
            64'({1'b0, tv[len], dv[len], 1'b1, 1'b1, 1'b0}));
      check($sformatf("%s hold tdo@%0d", tag, h), 64'(rsp_tdo[u]), 64'(exp_tdo));
    end
    rsp_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[u] = 1'b0;
    check({tag, " done pins"}, 64'(pins(u)), 64'({1'b0, tv[len], dv[len], 1'b0, 1'b0, 1'b1}));
  endtask

  initial begin
    int u, hold;
    logic [4:0]  len;
    logic [31:0] tv, dv, p;

    repeat (3) @(posedge clk);
    #1;
    check("reset pins0", 64'(pins(0)), 64'(6'b010001));
    check("reset pins1", 64'(pins(1)), 64'(6'b010001));
    check("reset tdo0", 64'(rsp_tdo[0]), 64'd0);
    @(negedge clk);
    rst_n = 2'b11;

    // TAP walk: reset, move to Shift-DR, read IDCODE under backpressure
    use_tap = 1'b1;
    run_cmd(0, 5'd4, 32'h1F, 32'h0, 32'h0, 0, "tap_reset");
    check("tap in TLR", 64'(tap_st), 64'(TLR));
    run_cmd(0, 5'd3, 32'h2, 32'h0, 32'h0, 0, "walk");
    check("tap in SHDR", 64'(tap_st), 64'(SHDR));
    dv = $urandom();
    run_cmd(0, 5'd31, 32'h8000_0000, dv, c_idcode, 20, "idcode");
    check("tap in EX1DR", 64'(tap_st), 64'(EX1DR));
    check("tap dr shifted", 64'(tap_dr), 64'(dv));
    use_tap = 1'b0;

    load_pattern(0, 32'hFFFF_FFFF);
    run_cmd(0, 5'd0, 32'h0, 32'h1, 32'h1, 0, "single");

    load_pattern(1, 32'hDEAD_BEA5);
    run_cmd(1, 5'd7, $urandom(), $urandom(), 32'h0000_00A5, 3, "mindiv");

    for (int i = 0; i < 12; i++) begin
      u    = int'($urandom_range(0, 1));
      len  = 5'($urandom_range(0, 31));
      tv   = $urandom();
      dv   = $urandom();
      p    = $urandom();
      hold = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
      load_pattern(u, p);
      run_cmd(u, len, tv, dv, p & len_mask(len), hold, $sformatf("rand%0d", i));
    end

    // Reset in the middle of bit 10's HIGH phase
    tv = $urandom() & ~32'h400;
    dv = $urandom() | 32'h400;
    load_pattern(0, $urandom());
    @(negedge clk);
    check("rst ready", 64'(cmd_ready[0]), 64'd1);
    cmd_valid[0] = 1'b1;
    cmd_len[0]   = 5'd31;
    cmd_tms[0]   = tv;
    cmd_tdi[0]   = dv;
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    repeat (21 * c_div0 + 1) @(posedge clk);
    #3;
    check("rst pre pins", 64'(pins(0)), 64'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}));
    rst_n[0] = 1'b0;
    #1;
    check("rst async pins", 64'(pins(0)), 64'(6'b010001));
    check("rst async tdo", 64'(rsp_tdo[0]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("post rst idle@%0d", n), 64'(pins(0)), 64'(6'b010001));
    end
    load_pattern(0, 32'h1234_5678);
    run_cmd(0, 5'd15, $urandom(), $urandom(), 32'h0000_5678, 2, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
